ceespu_text_console: RTL
========================

Name: ceespu_text_console

Overview:
- Character-stream terminal front end for the ceespu text-mode GPU.
- Accepts one byte at a time from the CPU-side register interface over a valid/ready handshake, and tracks the cursor.
- Generates cell writes (character + 16-bit fg/bg colour) for the GPU's text RAM and colour RAM write ports. Cell address = row*COLS + col.
- Handles CR, LF, BS and FF in hardware, and clears each newly entered line, so software never has to compute addresses.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, rows per screen.
- AW, 12, cell address width; must satisfy 2^AW >= COLS*ROWS.

Ports:
- I_sys_clk  in  1  system clock; all logic on its rising edge.
- I_sys_rst  in  1  reset, asynchronous, active-high.
- I_char_valid  in  1  byte offered.
- I_char  in  8  byte value.
- I_attr  in  16  colour word for this byte: [15:8] background, [7:0] foreground (RGB332).
- O_char_ready  out  1  block can accept a byte this cycle.
- O_ram_we  out  1  cell write strobe.
- O_ram_addr  out  AW  cell index.
- O_ram_char  out  8  character to write.
- O_ram_colour  out  16  colour word to write.
- O_cursor_col  out  7  current column.
- O_cursor_row  out  5  current row.
- O_busy  out  1  clear sequence in progress.

Behaviour:
- Reset (asynchronous, any time, including mid-clear):
  - O_ram_we=0, O_ram_addr=0, O_ram_char=0, O_ram_colour=0.
  - Cursor=(0,0), O_char_ready=0, O_busy=1.
  - Internal attribute register=16'h00FF.
  - State=CLEAR_ALL with clear counter=0.
  - Any in-progress clear is abandoned.
- Handshake: a byte is accepted on a rising edge where I_char_valid && O_char_ready. I_attr is captured into the attribute register on acceptance.
- O_char_ready is high only in IDLE. It is registered and drops the cycle after acceptance if the byte starts a clear.
- All RAM outputs are registered.
  - A write resulting from a byte accepted at edge N is presented with O_ram_we=1 for exactly one cycle after edge N.
  - O_ram_we is 0 on all other cycles.
- States:
  - IDLE:
    - 0x20..0x7E: write (char, attr) at cursor. Then col+1; if col was COLS-1, col=0 and row advances.
    - 0x0D (CR): col=0; no write.
    - 0x0A (LF): col=0; row advances.
    - 0x08 (BS): if col>0, col-1 and write 0x20 at the new position. At col 0, no-op; no wrap to the previous row.
    - 0x0C (FF): cursor=(0,0) and enter CLEAR_ALL.
    - All other bytes are consumed with no write and no cursor change.
  - Row advance:
    - row = (row==ROWS-1) ? 0 : row+1.
    - Then enter CLEAR_LINE for the new row.
    - When a printable byte wraps, its character write happens first (cycle N+1); clear writes start at cycle N+2.
  - CLEAR_LINE:
    - Writes 0x20 with the attribute register to cells row*COLS+0 .. row*COLS+COLS-1, one per cycle, ascending: COLS consecutive we cycles.
    - Returns to IDLE the cycle after the last write.
    - O_busy=1 and O_char_ready=0 throughout.
  - CLEAR_ALL:
    - Writes 0x20 with the attribute register to cells 0 .. COLS*ROWS-1, one per cycle: COLS*ROWS consecutive we cycles.
    - Then IDLE. O_busy=1, O_char_ready=0.
    - After reset, the attribute register is 16'h00FF.
- Address arithmetic: row*COLS+col is computed as (row<<6)+(row<<4)+col when COLS=80, otherwise as a generic multiply. It is a registered result, truncated to AW bits, and never exceeds COLS*ROWS-1.
- Cursor outputs are registered and update on the same edge as the corresponding RAM write.
- Bytes presented while O_char_ready=0 are neither accepted nor lost; the producer holds them.

Test Plan:
- Release reset, hold I_char_valid=0 → exactly 2400 consecutive we pulses, addr 0..2399, char 0x20, colour 16'h00FF; then O_busy=0, O_char_ready=1, cursor (0,0).
- Send 'A' (0x41), attr 16'h1CE0 → next cycle we=1, addr=0, char 0x41, colour 16'h1CE0; cursor (1,0).
- At cursor (79,2) send 'Z' → write at addr 239; cursor (0,3); then 80 clear writes at addr 240..319; ready low for those 80 cycles.
- At cursor (5,29) send LF → cursor (0,0); clear writes addr 0..79; CR at (5,3) → (0,3), no we.
- BS at (10,4) → write 0x20 at addr 329, cursor (9,4); BS at (0,4) → no write, cursor unchanged.
- FF, then assert reset at clear cycle 1000 → we=0 immediately; after release the full 2400-cell clear restarts from addr 0.

Source files
------------

// File: rtl/ceespu_text_console.sv
// Character-stream terminal front end: turns a byte stream into text/colour RAM
// cell writes and keeps the cursor, clearing lines and the screen in hardware.
module ceespu_text_console #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int AW   = 12
) (
  input  logic          I_sys_clk,
  input  logic          I_sys_rst,
  input  logic          I_char_valid,
  input  logic [7:0]    I_char,
  input  logic [15:0]   I_attr,
  output logic          O_char_ready,
  output logic          O_ram_we,
  output logic [AW-1:0] O_ram_addr,
  output logic [7:0]    O_ram_char,
  output logic [15:0]   O_ram_colour,
  output logic [6:0]    O_cursor_col,
  output logic [4:0]    O_cursor_row,
  output logic          O_busy
);

  localparam int CELLS = COLS * ROWS;
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_CLEAR_LINE = 2'd1;
  localparam logic [1:0] ST_CLEAR_ALL  = 2'd2;

  logic [1:0]    state_r, state_s;
  logic [6:0]    col_r, col_s;
  logic [4:0]    row_r, row_s;
  logic [15:0]   attr_r, attr_s;
  logic [AW:0]   clr_cnt_r, clr_cnt_s;
  logic          ram_we_r, ram_we_s;
  logic [AW-1:0] ram_addr_r, ram_addr_s;
  logic [7:0]    ram_char_r, ram_char_s;
  logic [15:0]   ram_colour_r, ram_colour_s;
  logic          ready_r, ready_s;
  logic          busy_r, busy_s;
  logic          accept_s;
  logic [4:0]    next_row_s;

  // Shift-add form for 80 columns avoids a multiplier on the common configuration.
  function automatic logic [AW-1:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    logic [31:0] sum_v;
    if (COLS == 80) begin
      sum_v = ({27'd0, row} << 6) + ({27'd0, row} << 4) + {25'd0, col};
    end else begin
      sum_v = ({27'd0, row} * 32'(COLS)) + {25'd0, col};
    end
    return sum_v[AW-1:0];
  endfunction

  assign accept_s   = I_char_valid && ready_r;
  assign next_row_s = (row_r == 5'(ROWS - 1)) ? 5'd0 : row_r + 5'd1;

  // Next-state, cursor and RAM-write decode for the console.
  always_comb begin
    state_s      = state_r;
    col_s        = col_r;
    row_s        = row_r;
    attr_s       = attr_r;
    clr_cnt_s    = clr_cnt_r;
    ram_we_s     = 1'b0;
    ram_addr_s   = ram_addr_r;
    ram_char_s   = ram_char_r;
    ram_colour_s = ram_colour_r;
    ready_s      = ready_r;
    busy_s       = busy_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          attr_s = I_attr;
          if ((I_char >= 8'h20) && (I_char <= 8'h7E)) begin
            ram_we_s     = 1'b1;
            ram_addr_s   = cell_addr(row_r, col_r);
            ram_char_s   = I_char;
            ram_colour_s = I_attr;
            if (col_r == 7'(COLS - 1)) begin
              col_s     = 7'd0;
              row_s     = next_row_s;
              state_s   = ST_CLEAR_LINE;
              clr_cnt_s = '0;
              ready_s   = 1'b0;
              busy_s    = 1'b1;
            end else begin
              col_s = col_r + 7'd1;
            end
          end else begin
            case (I_char)
              8'h0D: col_s = 7'd0;
              8'h0A: begin
                col_s     = 7'd0;
                row_s     = next_row_s;
                state_s   = ST_CLEAR_LINE;
                clr_cnt_s = '0;
                ready_s   = 1'b0;
                busy_s    = 1'b1;
              end
              8'h08: begin
                if (col_r != 7'd0) begin
                  col_s        = col_r - 7'd1;
                  ram_we_s     = 1'b1;
                  ram_addr_s   = cell_addr(row_r, col_r - 7'd1);
                  ram_char_s   = 8'h20;
                  ram_colour_s = I_attr;
                end else begin
                  col_s = col_r;
                end
              end
              8'h0C: begin
                col_s     = 7'd0;
                row_s     = 5'd0;
                state_s   = ST_CLEAR_ALL;
                clr_cnt_s = '0;
                ready_s   = 1'b0;
                busy_s    = 1'b1;
              end
              default: col_s = col_r;
            endcase
          end
        end else begin
          attr_s = attr_r;
        end
      end
      ST_CLEAR_LINE: begin
        if (clr_cnt_r == (AW+1)'(COLS)) begin
          state_s = ST_IDLE;
          ready_s = 1'b1;
          busy_s  = 1'b0;
        end else begin
          ram_we_s     = 1'b1;
          ram_addr_s   = cell_addr(row_r, clr_cnt_r[6:0]);
          ram_char_s   = 8'h20;
          ram_colour_s = attr_r;
          clr_cnt_s    = clr_cnt_r + (AW+1)'(1);
        end
      end
      ST_CLEAR_ALL: begin
        if (clr_cnt_r == (AW+1)'(CELLS)) begin
          state_s = ST_IDLE;
          ready_s = 1'b1;
          busy_s  = 1'b0;
        end else begin
          ram_we_s     = 1'b1;
          ram_addr_s   = clr_cnt_r[AW-1:0];
          ram_char_s   = 8'h20;
          ram_colour_s = attr_r;
          clr_cnt_s    = clr_cnt_r + (AW+1)'(1);
        end
      end
      default: begin
        state_s   = ST_CLEAR_ALL;
        clr_cnt_s = '0;
        ready_s   = 1'b0;
        busy_s    = 1'b1;
      end
    endcase
  end

  // State and output registers; reset restarts a full-screen clear.
  always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
    if (I_sys_rst) begin
      state_r      <= ST_CLEAR_ALL;
      col_r        <= 7'd0;
      row_r        <= 5'd0;
      attr_r       <= 16'h00FF;
      clr_cnt_r    <= '0;
      ram_we_r     <= 1'b0;
      ram_addr_r   <= '0;
      ram_char_r   <= 8'h00;
      ram_colour_r <= 16'h0000;
      ready_r      <= 1'b0;
      busy_r       <= 1'b1;
    end else begin
      state_r      <= state_s;
      col_r        <= col_s;
      row_r        <= row_s;
      attr_r       <= attr_s;
      clr_cnt_r    <= clr_cnt_s;
      ram_we_r     <= ram_we_s;
      ram_addr_r   <= ram_addr_s;
      ram_char_r   <= ram_char_s;
      ram_colour_r <= ram_colour_s;
      ready_r      <= ready_s;
      busy_r       <= busy_s;
    end
  end

  assign O_char_ready = ready_r;
  assign O_ram_we     = ram_we_r;
  assign O_ram_addr   = ram_addr_r;
  assign O_ram_char   = ram_char_r;
  assign O_ram_colour = ram_colour_r;
  assign O_cursor_col = col_r;
  assign O_cursor_row = row_r;
  assign O_busy       = busy_r;

endmodule
